// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point defaults, engine state encoding and the
// saturate/truncate helpers used by every MAC in the engine.
package nn_fixed_pkg;

    localparam int N_DEF = 32;
    localparam int F_DEF = 16;
    localparam int WIDE  = 128;

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_UPD = 1'b1
    } state_t;

    // Clamp x to the signed range of a w-bit word.
    function automatic logic signed [WIDE-1:0] sat_w(input logic signed [WIDE-1:0] x,
                                                     input int w);
        logic signed [WIDE-1:0] hi;
        logic signed [WIDE-1:0] lo;
        hi = (WIDE'(1) << (w - 1)) - WIDE'(1);
        lo = ~hi;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    // Bits [w+f-1:f] of a product, sign-extended back to WIDE bits.
    function automatic logic signed [WIDE-1:0] trunc_frac(input logic signed [WIDE-1:0] p,
                                                          input int f,
                                                          input int w);
        logic signed [WIDE-1:0] s;
        s = p >>> f;
        s = s <<< (WIDE - w);
        return s >>> (WIDE - w);
    endfunction

endpackage

// File: rtl/sat_mac.sv
// Fixed-point multiply (or bias bypass), truncate, add/subtract into an
// accumulator operand and saturate to the accumulator width.
module sat_mac
    import nn_fixed_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int F     = F_DEF,
    parameter int ACC_W = N_DEF
) (
    input  logic signed [N-1:0]     a,
    input  logic signed [N-1:0]     b,
    input  logic                    bypass,
    input  logic                    sub,
    input  logic signed [ACC_W-1:0] acc_in,
    output logic signed [ACC_W-1:0] acc_out
);

    logic signed [WIDE-1:0] a_w;
    logic signed [WIDE-1:0] b_w;
    logic signed [WIDE-1:0] acc_w;
    logic signed [WIDE-1:0] term_w;
    logic signed [WIDE-1:0] sum_w;

    always_comb begin
        a_w     = WIDE'(a);
        b_w     = WIDE'(b);
        acc_w   = WIDE'(acc_in);
        term_w  = bypass ? a_w : trunc_frac(a_w * b_w, F, N);
        sum_w   = sub ? (acc_w - term_w) : (acc_w + term_w);
        acc_out = ACC_W'(sat_w(sum_w, ACC_W));
    end

endmodule

// File: rtl/sgd_update_engine.sv
// Parameter store with mini-batch gradient accumulation and a serial,
// one-index-per-cycle SGD update pass that streams each new parameter out.
module sgd_update_engine
    import nn_fixed_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int F     = F_DEF,
    parameter int NP    = 17,
    parameter int BLOG2 = 2,
    parameter int AW    = $clog2(NP)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [N-1:0] rate,
    input  logic                ld_valid,
    input  logic [AW-1:0]       ld_idx,
    input  logic signed [N-1:0] ld_data,
    input  logic [AW-1:0]       rd_idx,
    output logic signed [N-1:0] rd_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [AW-1:0]       in_idx,
    input  logic signed [N-1:0] in_err,
    input  logic signed [N-1:0] in_act,
    input  logic                in_bias,
    input  logic                in_last,
    output logic                out_valid,
    output logic [AW-1:0]       out_idx,
    output logic signed [N-1:0] out_data,
    output logic                done
);

    localparam int ACC_W = N + BLOG2;
    localparam logic [AW:0]    NP_W       = (AW+1)'(NP);
    localparam logic [AW:0]    K_ONE      = (AW+1)'(1);
    localparam logic [BLOG2:0] BATCH_LAST = (BLOG2+1)'((1 << BLOG2) - 1);
    localparam logic [BLOG2:0] SMP_ONE    = (BLOG2+1)'(1);

    logic signed [N-1:0]     param [NP];
    logic signed [ACC_W-1:0] acc   [NP];

    state_t              state, state_nx;
    logic [AW:0]         k_p0;
    logic [BLOG2:0]      smp_cnt;
    logic signed [N-1:0] rate_q;

    logic                    acc_fire, in_ok, ld_ok, rd_ok, batch_end, upd_issue;
    logic [AW-1:0]           in_sel, k_sel;
    logic signed [ACC_W-1:0] acc_nx;
    logic signed [WIDE-1:0]  avg_w;
    logic signed [N-1:0]     avg_p0;
    logic signed [N-1:0]     upd_val;

    assign in_ready  = (state == ST_ACC);
    assign acc_fire  = in_valid & in_ready;
    assign in_ok     = {1'b0, in_idx} < NP_W;
    assign ld_ok     = {1'b0, ld_idx} < NP_W;
    assign rd_ok     = {1'b0, rd_idx} < NP_W;
    assign in_sel    = in_ok ? in_idx : '0;
    assign batch_end = acc_fire & in_last & (smp_cnt == BATCH_LAST);
    assign rd_data   = rd_ok ? param[rd_idx] : '0;

    assign upd_issue = (state == ST_UPD) && (k_p0 < NP_W);
    assign k_sel     = upd_issue ? k_p0[AW-1:0] : '0;
    assign avg_w     = sat_w(WIDE'(acc[k_sel]) >>> BLOG2, N);
    assign avg_p0    = avg_w[N-1:0];

    sat_mac #(.N(N), .F(F), .ACC_W(ACC_W)) u_acc_mac (
        .a       (in_err),
        .b       (in_act),
        .bypass  (in_bias),
        .sub     (1'b0),
        .acc_in  (acc[in_sel]),
        .acc_out (acc_nx)
    );

    sat_mac #(.N(N), .F(F), .ACC_W(N)) u_upd_mac (
        .a       (rate_q),
        .b       (avg_p0),
        .bypass  (1'b0),
        .sub     (1'b1),
        .acc_in  (param[k_sel]),
        .acc_out (upd_val)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_ACC:  if (batch_end) state_nx = ST_UPD;
            ST_UPD:  if (k_p0 == NP_W) state_nx = ST_ACC;
            default: state_nx = ST_ACC;
        endcase
    end

    // Stage p0 reads and multiplies; the edge below writes the result back
    // and registers it onto the output stream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_ACC;
            k_p0      <= '0;
            smp_cnt   <= '0;
            rate_q    <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            out_valid <= upd_issue;
            done      <= (state == ST_UPD) && (k_p0 == NP_W);
            if (batch_end) begin
                smp_cnt <= '0;
                rate_q  <= rate;
            end else if (acc_fire && in_last) begin
                smp_cnt <= smp_cnt + SMP_ONE;
            end
            if (state == ST_UPD && k_p0 != NP_W) k_p0 <= k_p0 + K_ONE;
            else                                 k_p0 <= '0;
            if (upd_issue) begin
                out_idx  <= k_sel;
                out_data <= upd_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NP; i++) begin
                param[i] <= '0;
                acc[i]   <= '0;
            end
        end else if (state == ST_ACC) begin
            if (ld_valid && ld_ok)  param[ld_idx] <= ld_data;
            if (acc_fire && in_ok)  acc[in_idx]   <= acc_nx;
        end else if (upd_issue) begin
            param[k_sel] <= upd_val;
            acc[k_sel]   <= '0;
        end
    end

endmodule

// File: tb/tb_sgd_update_engine.sv
// Randomised and directed bench for sgd_update_engine against a
// plain-arithmetic model of the parameter and accumulator store.
module tb_sgd_update_engine;

    localparam int NP    = 17;
    localparam int AW    = 5;
    localparam int BATCH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   rate, ld_data, in_err, in_act;
    logic          ld_valid, in_valid, in_bias, in_last;
    logic [AW-1:0] ld_idx, rd_idx, in_idx;
    logic [31:0]   rd_data, out_data;
    logic          in_ready, out_valid, done;
    logic [AW-1:0] out_idx;

    always #5 clk = ~clk;

    sgd_update_engine #(.N(32), .F(16), .NP(NP), .BLOG2(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .rate      (rate),
        .ld_valid  (ld_valid),
        .ld_idx    (ld_idx),
        .ld_data   (ld_data),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_idx    (in_idx),
        .in_err    (in_err),
        .in_act    (in_act),
        .in_bias   (in_bias),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .done      (done)
    );

    longint      m_param [NP];
    longint      m_acc   [NP];
    int          m_smp;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [$];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint clampw(input longint x, input int w);
        longint hi, lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    function automatic longint trunc32(input longint p);
        longint s;
        s = p >>> 16;
        return longint'(int'(s[31:0]));
    endfunction

    function automatic longint sx(input logic [31:0] v);
        return longint'(int'(v));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_param[i] = 0;
            m_acc[i]   = 0;
        end
        m_smp = 0;
    endtask

    task automatic build_expect();
        longint avg, dw, nv;
        exp_q.delete();
        for (int k = 0; k < NP; k++) begin
            avg        = clampw(m_acc[k] >>> 2, 32);
            dw         = trunc32(sx(rate) * avg);
            nv         = clampw(m_param[k] - dw, 32);
            m_param[k] = nv;
            m_acc[k]   = 0;
            exp_q.push_back(nv[31:0]);
        end
    endtask

    task automatic run_upd(input bit ld_poke);
        for (int cyc = 0; cyc <= NP + 1; cyc++) begin
            if (cyc > 0) tick();
            ld_valid = 1'b0;
            check_val("in_ready_upd", 64'(in_ready), 64'(cyc == NP + 1));
            check_val("out_valid", 64'(out_valid), 64'(cyc >= 1 && cyc <= NP));
            check_val("done", 64'(done), 64'(cyc == NP + 1));
            if (cyc >= 1 && cyc <= NP) begin
                check_val("out_idx", 64'(out_idx), 64'(cyc - 1));
                check_val("out_data", 64'(out_data), 64'(exp_q[cyc-1]));
            end
            if (ld_poke && cyc == 3) begin
                ld_valid = 1'b1;
                ld_idx   = AW'(5);
                ld_data  = $urandom;
            end
        end
    endtask

    task automatic check_rd_all();
        for (int i = 0; i < NP; i++) begin
            rd_idx = AW'(i);
            #2;
            check_val("rd_data", 64'(rd_data), 64'(m_param[i][31:0]));
            tick();
        end
    endtask

    task automatic ld_only(input int idx, input logic [31:0] d);
        ld_valid = 1'b1;
        ld_idx   = AW'(idx);
        ld_data  = d;
        if (idx < NP) m_param[idx] = sx(d);
        tick();
        ld_valid = 1'b0;
    endtask

    // Drives one gradient term (optionally with a load in the same cycle);
    // a batch-final term either runs the full update check or aborts it by reset.
    task automatic drive_term(input int idx, input logic [31:0] err, input logic [31:0] act,
                              input bit bias, input bit last, input bit ldv, input int ldi,
                              input logic [31:0] ldd, input bit poke, input bit abort);
        bit batch;
        batch = 1'b0;
        check_val("in_ready_acc", 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        in_idx   = AW'(idx);
        in_err   = err;
        in_act   = act;
        in_bias  = bias;
        in_last  = last;
        ld_valid = ldv;
        ld_idx   = AW'(ldi);
        ld_data  = ldd;
        if (ldv && ldi < NP) m_param[ldi] = sx(ldd);
        if (idx < NP)
            m_acc[idx] = clampw(m_acc[idx] + (bias ? sx(err) : trunc32(sx(err) * sx(act))), 34);
        if (last) begin
            m_smp++;
            if (m_smp == BATCH) begin
                m_smp = 0;
                batch = 1'b1;
                build_expect();
            end
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_bias  = 1'b0;
        ld_valid = 1'b0;
        if (batch && !abort) run_upd(poke);
        if (batch && abort) begin
            repeat (5) tick();
            rst = 1'b0;
            #2;
            check_val("rst_out_valid", 64'(out_valid), 64'(0));
            check_val("rst_out_idx", 64'(out_idx), 64'(0));
            check_val("rst_out_data", 64'(out_data), 64'(0));
            check_val("rst_done", 64'(done), 64'(0));
            rst = 1'b1;
            model_reset();
            tick();
            check_val("rst_in_ready", 64'(in_ready), 64'(1));
            check_rd_all();
        end
    endtask

    task automatic random_batch(input bit abort);
        int nt;
        rate = $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 32'h0003_0000);
        for (int s = 0; s < BATCH; s++) begin
            nt = $urandom_range(1, 4);
            for (int t = 0; t < nt; t++)
                drive_term($urandom_range(0, NP), $urandom, $urandom, 1'($urandom_range(0, 1)),
                           t == nt - 1, 1'($urandom_range(0, 1)), $urandom_range(0, NP),
                           $urandom, 1'b0, abort);
        end
    endtask

    initial begin
        rst = 1'b0;
        rate = '0; ld_valid = 1'b0; ld_idx = '0; ld_data = '0; rd_idx = '0;
        in_valid = 1'b0; in_idx = '0; in_err = '0; in_act = '0; in_bias = 1'b0; in_last = 1'b0;
        model_reset();
        #12;
        check_val("reset_in_ready", 64'(in_ready), 64'(1));
        check_val("reset_out_valid", 64'(out_valid), 64'(0));
        check_val("reset_out_idx", 64'(out_idx), 64'(0));
        check_val("reset_out_data", 64'(out_data), 64'(0));
        check_val("reset_done", 64'(done), 64'(0));
        check_val("reset_rd_data", 64'(rd_data), 64'(0));
        rst = 1'b1;
        tick();

        // Single product term per sample on index 3.
        rate = 32'h0001_999A;
        ld_only(3, 32'h0001_0000);
        for (int s = 0; s < BATCH; s++)
            drive_term(3, 32'h0001_0000, 32'h0000_8000, 1'b0, 1'b1, 1'b0, 0, '0, 1'b0, 1'b0);
        rd_idx = AW'(3); #2;
        check_val("t1_param3", 64'(rd_data), 64'(32'h0000_3333));

        // Bias terms: activation must be ignored.
        rate = 32'h0001_0000;
        for (int s = 0; s < BATCH; s++)
            drive_term(0, 32'h0004_0000, $urandom, 1'b1, 1'b1, 1'b0, 0, '0, 1'b0, 1'b0);
        rd_idx = AW'(0); #2;
        check_val("t2_param0", 64'(rd_data), 64'(32'hFFFC_0000));

        // Accumulator saturation followed by output saturation.
        ld_only(1, 32'h7FFF_FFFF);
        for (int t = 0; t < 4; t++)
            drive_term(1, 32'h8000_0000, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0);
        for (int s = 0; s < BATCH; s++)
            drive_term(1, 32'h8000_0000, 32'h0001_0000, 1'b0, 1'b1, 1'b0, 0, '0, 1'b0, 1'b0);
        rd_idx = AW'(1); #2;
        check_val("t3_param1_sat", 64'(rd_data), 64'(32'h7FFF_FFFF));

        // Load and term on index 2 together, an out-of-range sample, load during UPD.
        rate = 32'h0000_8000;
        drive_term(2, 32'h0002_0000, 32'h0001_0000, 1'b0, 1'b1, 1'b1, 2, 32'h0003_0000, 1'b0, 1'b0);
        drive_term(NP, 32'h7000_0000, 32'h7000_0000, 1'b0, 1'b1, 1'b1, NP, 32'h1234_5678, 1'b0, 1'b0);
        drive_term(2, 32'h0002_0000, 32'h0001_0000, 1'b1, 1'b1, 1'b0, 0, '0, 1'b0, 1'b0);
        drive_term(5, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1, 1'b0, 0, '0, 1'b1, 1'b0);
        check_rd_all();

        for (int b = 0; b < 6; b++) random_batch(1'b0);
        check_rd_all();

        random_batch(1'b1);
        random_batch(1'b0);
        check_rd_all();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
